// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider: FSM states, start/stop and ready levels.
package div_pkg;

  typedef enum logic [1:0] {
    DIVFREE   = 2'b00,
    DIVBYZERO = 2'b01,
    DIVON     = 2'b10,
    DIVEND    = 2'b11
  } div_state_e;

  localparam logic RSTENABLE         = 1'b1;
  localparam logic DIVSTART          = 1'b1;
  localparam logic DIVSTOP           = 1'b0;
  localparam logic DIVRESULTREADY    = 1'b1;
  localparam logic DIVRESULTNOTREADY = 1'b0;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned N_STEPS = 32;

  // Magnitude of a 32-bit operand; only negated when treated as signed and negative.
  function automatic logic [31:0] abs_val(input logic is_signed, input logic [31:0] x);
    return (is_signed && x[31]) ? 32'(-x) : x;
  endfunction

endpackage

// File: rtl/div.sv
// 32-bit restoring divider (DIV/DIVU): one quotient bit per cycle,
// result {remainder, quotient} held until the requester releases it.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e         state;
  logic [64:0]        work;
  logic [31:0]        divisor;
  logic [CNT_W-1:0]   cnt;
  logic               neg_quo;
  logic               neg_rem;

  logic [32:0]        diff_c;
  logic [31:0]        quo_c;
  logic [31:0]        rem_c;

  // Trial subtraction of the magnitude divisor from the partial remainder.
  assign diff_c = {1'b0, work[63:32]} - {1'b0, divisor};
  assign quo_c  = neg_quo ? 32'(-work[31:0])  : work[31:0];
  assign rem_c  = neg_rem ? 32'(-work[64:33]) : work[64:33];

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RSTENABLE) begin
      state    <= DIVFREE;
      work     <= 65'd0;
      divisor  <= 32'd0;
      cnt      <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= DIVRESULTNOTREADY;
    end else begin
      case (state)
        DIVFREE: begin
          result_o <= 64'd0;
          ready_o  <= DIVRESULTNOTREADY;
          if (start_i == DIVSTART && !annul_i) begin
            neg_quo <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem <= signed_div_i && opdata1_i[31];
            divisor <= abs_val(signed_div_i, opdata2_i);
            work    <= {32'd0, abs_val(signed_div_i, opdata1_i), 1'b0};
            cnt     <= '0;
            state   <= (opdata2_i == 32'd0) ? DIVBYZERO : DIVON;
          end
        end

        DIVBYZERO: begin
          if (annul_i) begin
            state <= DIVFREE;
          end else begin
            result_o <= 64'd0;
            ready_o  <= DIVRESULTREADY;
            state    <= DIVEND;
          end
        end

        DIVON: begin
          if (annul_i) begin
            state <= DIVFREE;
            cnt   <= '0;
          end else if (cnt != CNT_W'(N_STEPS)) begin
            if (diff_c[32]) begin
              work <= {work[63:0], 1'b0};
            end else begin
              work <= {diff_c[31:0], work[31:0], 1'b1};
            end
            cnt <= cnt + CNT_W'(1);
          end else begin
            // Sign fix-up; 0x80000000 / -1 simply wraps back to 0x80000000.
            result_o <= {rem_c, quo_c};
            ready_o  <= DIVRESULTREADY;
            state    <= DIVEND;
            cnt      <= '0;
          end
        end

        DIVEND: begin
          if (start_i == DIVSTOP) begin
            state    <= DIVFREE;
            result_o <= 64'd0;
            ready_o  <= DIVRESULTNOTREADY;
          end
        end

        default: state <= DIVFREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: arithmetic reference model with per-cycle
// comparison, directed literal cases and randomized traffic.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int vectors = 0;
  int miscompares = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Expected {remainder, quotient} from plain integer arithmetic.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted request yields its result a fixed
  // number of edges later unless annulled; release on start dropping.
  logic        m_ready;
  logic [63:0] m_res;
  logic [63:0] m_pend;
  logic        m_busy;
  int          m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b0;
      m_res   <= 64'd0;
      m_pend  <= 64'd0;
      m_busy  <= 1'b0;
      m_left  <= 0;
    end else if (m_ready) begin
      if (!start_i) begin
        m_ready <= 1'b0;
        m_res   <= 64'd0;
      end
    end else if (m_busy) begin
      if (annul_i) begin
        m_busy <= 1'b0;
      end else if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
        m_res   <= m_pend;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (start_i && !annul_i) begin
      m_busy <= 1'b1;
      m_pend <= ref_div(opdata1_i, opdata2_i, signed_div_i);
      m_left <= (opdata2_i == 32'd0) ? 1 : 33;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_ready", {63'd0, ready_o}, {63'd0, m_ready});
      chk("cyc_result", result_o, m_res);
    end
  end

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp, input int exp_edges);
    int n;
    @(negedge clk);
    opdata1_i = a; opdata2_i = b; signed_div_i = s; start_i = 1'b1; annul_i = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (ready_o) break;
    end
    chk({name, "_latency"}, 64'(n), 64'(exp_edges));
    chk({name, "_result"}, result_o, exp);
    chk({name, "_model"}, ref_div(a, b, s), exp);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({name, "_release_ready"}, {63'd0, ready_o}, 64'd0);
    chk({name, "_release_result"}, result_o, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("udiv_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 34);
    run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    run_op("udiv_fff9_2", 32'hFFFF_FFF9, 32'd2, 1'b0, {32'd1, 32'h7FFF_FFFC}, 34);
    run_op("div_by_zero", 32'd5, 32'd0, 1'b0, 64'd0, 2);
    run_op("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 34);

    // Annul once the counter has reached 10.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    repeat (40) begin
      @(negedge clk);
      chk("annul_noready", {63'd0, ready_o}, 64'd0);
    end
    run_op("after_annul_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 34);

    // Asynchronous reset mid-DIVON.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_divon_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_divon_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    run_op("after_rst_8_8", 32'd8, 32'd8, 1'b0, {32'd0, 32'd1}, 34);

    // Asynchronous reset while a result is being held.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (34) @(posedge clk);
    #2;
    chk("divend_hold", result_o, {32'd2, 32'd14});
    rst = 1'b1;
    #1;
    chk("rst_divend_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_divend_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;

    // Random traffic: inputs churn every cycle, including mid-operation.
    repeat (3000) begin
      @(negedge clk);
      start_i      = ($urandom % 8) != 0;
      annul_i      = ($urandom % 64) == 0;
      signed_div_i = 1'($urandom % 2);
      opdata1_i    = pick();
      opdata2_i    = (($urandom % 16) == 0) ? 32'd0 : pick();
    end
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
